// File: rtl/z16_prog_loader_if.sv
// Host byte stream and instruction-memory write port of the Z16 program loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface z16_prog_loader_if;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        o_mem_wen;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_data;

    modport master (
        output i_rx_valid,
        output i_rx_data,
        input  o_rx_ready,
        input  o_mem_wen,
        input  o_mem_addr,
        input  o_mem_data
    );

    modport slave (
        input  i_rx_valid,
        input  i_rx_data,
        output o_rx_ready,
        output o_mem_wen,
        output o_mem_addr,
        output o_mem_data
    );
endinterface

// File: rtl/z16_prog_loader.sv
// Z16 program loader: parses SYNC, LEN (words), data frames into instruction memory
// and holds the CPU in reset until load completes. Z16_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module z16_prog_loader #(
    parameter int          MEM_BYTES = 512,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    z16_prog_loader_if.slave   bus,
    output logic               o_cpu_rst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 2);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_DONE,
        ST_ERR
`ifdef Z16_LOADER_CHECKSUM_EN
        , ST_CSUM
`endif
    } state_t;

`ifdef Z16_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = ST_CSUM;
`else
    localparam state_t END_STATE = ST_DONE;
`endif

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic        wen_d;
    logic [15:0] addr_d;
    logic [15:0] data_d;
    logic        ready_d;
    logic        accept;
`ifdef Z16_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    assign accept = bus.i_rx_valid && bus.o_rx_ready;

    // Next-state and datapath decode; a write is issued the cycle after the high byte lands
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        lo_d    = lo_q;
        wen_d   = 1'b0;
        addr_d  = bus.o_mem_addr;
        data_d  = bus.o_mem_data;
`ifdef Z16_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_SYNC: begin
                if (accept && bus.i_rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d   = {8'h00, bus.i_rx_data};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = {bus.i_rx_data, len_q[7:0]};
                    idx_d = 16'h0000;
`ifdef Z16_LOADER_CHECKSUM_EN
                    csum_d = 8'h00;
`endif
                    if (len_d == 16'h0000) begin
                        state_d = END_STATE;
                    end else if (len_d > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA_LO;
                    end
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    lo_d    = bus.i_rx_data;
`ifdef Z16_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ bus.i_rx_data;
`endif
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    wen_d  = 1'b1;
                    addr_d = {idx_q[14:0], 1'b0};
                    data_d = {bus.i_rx_data, lo_q};
`ifdef Z16_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.i_rx_data;
`endif
                    idx_d  = idx_q + 16'd1;
                    if (idx_d == len_q) begin
                        state_d = END_STATE;
                    end else begin
                        state_d = ST_DATA_LO;
                    end
                end
            end
`ifdef Z16_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (bus.i_rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_SYNC;
        endcase
        ready_d = (state_d != ST_DONE) && (state_d != ST_ERR);
    end

    // Ready follows the next state so no byte is taken once the frame has ended;
    // status flags follow the current state and so trail the final write by one cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= ST_SYNC;
            len_q          <= 16'h0000;
            idx_q          <= 16'h0000;
            lo_q           <= 8'h00;
`ifdef Z16_LOADER_CHECKSUM_EN
            csum_q         <= 8'h00;
`endif
            bus.o_rx_ready <= 1'b0;
            bus.o_mem_wen  <= 1'b0;
            bus.o_mem_addr <= 16'h0000;
            bus.o_mem_data <= 16'h0000;
            o_cpu_rst      <= 1'b1;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            lo_q           <= lo_d;
`ifdef Z16_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
            bus.o_rx_ready <= ready_d;
            bus.o_mem_wen  <= wen_d;
            bus.o_mem_addr <= addr_d;
            bus.o_mem_data <= data_d;
            o_cpu_rst      <= (state_q != ST_DONE);
            o_busy         <= (state_q != ST_SYNC) && (state_q != ST_DONE) && (state_q != ST_ERR);
            o_done         <= (state_q == ST_DONE);
            o_err          <= (state_q == ST_ERR);
        end
    end

endmodule

// File: doc/z16_prog_loader.md
Name: z16_prog_loader

Overview:
- Writer side of the Z16 instruction memory: receives a framed byte stream from a host link (UART RX / debug port) and writes 16-bit instruction words into instruction memory at byte addresses 0, 2, 4, …, matching the CPU's PC stepping of +2.
- Holds the CPU in reset until a program has loaded cleanly, then releases it so execution starts from PC 0x0000.
- Sits between the host byte source and the instruction-memory write port, beside the CPU core.

Parameters:
- MEM_BYTES, 512, instruction memory size in bytes; maximum program length is MEM_BYTES/2 words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- i_clk  in  1  clock, single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_valid  in  1  byte available on i_rx_data.
- i_rx_data  in  8  received byte.
- o_rx_ready  out  1  loader can accept a byte; a transfer occurs when i_rx_valid && o_rx_ready.
- o_mem_wen  out  1  instruction memory write strobe, one-cycle pulse.
- o_mem_addr  out  16  write byte address, always even.
- o_mem_data  out  16  write data word.
- o_cpu_rst  out  1  reset to CPU core; high until load completes.
- o_busy  out  1  frame in progress.
- o_done  out  1  load complete, sticky.
- o_err  out  1  frame rejected, sticky.

Behaviour:
- Reset:
  - All outputs are registered.
  - While i_rst is high: o_rx_ready=0, o_mem_wen=0, o_mem_addr=0, o_mem_data=0, o_cpu_rst=1, o_busy=0, o_done=0, o_err=0, state=SYNC.
  - o_rx_ready rises in the first cycle after i_rst falls.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 2*LEN data bytes. Each word is sent low byte first. LEN is an unsigned word count.
- States: SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, [CSUM], DONE, ERR.
- SYNC: bytes other than SYNC_BYTE are accepted and discarded. SYNC_BYTE -> LEN_LO and o_busy=1.
- LEN_HI accept:
  - LEN==0 -> DONE (or CSUM when the optional feature is enabled).
  - LEN > MEM_BYTES/2 -> ERR.
  - Otherwise -> DATA_LO, with word index=0.
- DATA_LO accept: low byte is latched -> DATA_HI.
- DATA_HI accept:
  - In the next cycle, o_mem_wen=1 for exactly one cycle, with o_mem_addr=2*index and o_mem_data={hi,lo}.
  - Index increments. If index reaches LEN -> DONE (or CSUM), else -> DATA_LO.
  - o_rx_ready stays high, so back-to-back bytes are legal and at most one write is pending.
- DONE:
  - Entered the cycle after the last o_mem_wen pulse (or after the CSUM/LEN_HI accept).
  - o_done=1, o_cpu_rst=0, o_busy=0, o_rx_ready=0.
  - Stays in DONE until i_rst.
- ERR: o_err=1, o_cpu_rst=1, o_busy=0, o_rx_ready=0. Stays in ERR until i_rst.
- Valid gaps: any number of idle cycles between bytes; state holds.
- Reset mid-frame: i_rst aborts the frame immediately. A pending write strobe is suppressed; the memory already written is left untouched.
- Address arithmetic: 16-bit, 2*index. Index is never greater than MEM_BYTES/2-1, so the address never wraps.

Optional Feature:
- Macro: Z16_LOADER_CHECKSUM_EN.
- When defined:
  - A CSUM state follows the last data byte (or LEN_HI when LEN==0) and accepts one byte.
  - The expected value is the XOR of all data bytes, with initial value 8'h00.
  - Match -> DONE; mismatch -> ERR.
  - All words have already been written at that point; CPU reset stays asserted on mismatch.
- When undefined: no CSUM state, and the frame ends after the last data byte.

Test Plan:
- A5 02 00 34 12 78 56 back-to-back -> wen pulses addr 0x0000 data 0x1234 and addr 0x0002 data 0x5678; o_done=1 and o_cpu_rst=0 one cycle after the second pulse.
- 00 FF A5 01 00 CD AB with 3 idle cycles between each byte -> leading bytes discarded; single write addr 0x0000 data 0xABCD; then done.
- A5 00 00 -> no wen pulse; o_done=1, o_cpu_rst=0; o_rx_ready=0 afterwards, and further bytes are not accepted.
- MEM_BYTES=512, A5 01 01 (LEN=257) -> o_err=1, o_cpu_rst=1, o_rx_ready=0, no writes; the state is held until i_rst.
- A5 02 00 34, then i_rst for 1 cycle -> no write, all outputs at reset values; a subsequent full frame A5 01 00 11 22 writes addr 0 data 0x2211 and completes.
- With Z16_LOADER_CHECKSUM_EN defined:
  - A5 01 00 34 12 26 -> write 0x1234, then done.
  - A5 01 00 34 12 27 -> write 0x1234, then o_err=1, o_cpu_rst stays 1.
